// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte queue behind the UART receiver.
// Adds a sticky overrun flag, a fill-threshold interrupt and an idle timeout.
module uart_rx_fifo #(
  parameter int unsigned AW         = 4,
  parameter logic [15:0] TMO_CYCLES = 16'd5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_stb,
  input  logic          rd_en,
  input  logic [AW:0]   thresh,
  input  logic          ovr_clr,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovr,
  output logic          tmo,
  output logic          irq
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          stb_q;
  logic          ovr_q, ovr_d;
  logic [15:0]   tmo_ctr_q, tmo_ctr_d;

  logic push, pop, wr_en, ovr_set;

  always_comb begin
    push    = rx_stb & ~stb_q;
    pop     = rd_en & ~empty;
    // A full queue still takes a byte when a pop frees a slot in the same cycle.
    wr_en   = push & (~full | pop);
    ovr_set = push & full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    ovr_d = ovr_q;
    if (ovr_set)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;

    tmo_ctr_d = tmo_ctr_q;
    if (push || pop || empty)       tmo_ctr_d = 16'd0;
    else if (tmo_ctr_q != TMO_CYCLES) tmo_ctr_d = tmo_ctr_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stb_q     <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_ctr_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      stb_q     <= rx_stb;
      ovr_q     <= ovr_d;
      tmo_ctr_q <= tmo_ctr_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);
  assign count = count_q;
  assign ovr   = ovr_q;
  assign tmo   = (tmo_ctr_q == TMO_CYCLES);
  assign irq   = ((thresh != '0) && (count_q >= thresh)) || tmo;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, all
// compared against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 20;

  logic          clk, rst;
  logic [7:0]    rx_data;
  logic          rx_stb, rd_en, ovr_clr;
  logic [AW:0]   thresh;
  logic [7:0]    dout;
  logic          empty, full, ovr, tmo, irq;
  logic [AW:0]   count;

  uart_rx_fifo #(.AW(AW), .TMO_CYCLES(16'(TMO))) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb), .rd_en(rd_en),
    .thresh(thresh), .ovr_clr(ovr_clr), .dout(dout), .empty(empty),
    .full(full), .count(count), .ovr(ovr), .tmo(tmo), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         ovr_m;
  bit         prev_stb;
  int         idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ovr_m    = 1'b0;
    prev_stb = 1'b0;
    idle     = 0;
  endtask

  task automatic compare_all();
    bit tmo_m;
    tmo_m = (idle == TMO);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full",  32'(full),  32'(mq.size() == DEPTH));
    chk("ovr",   32'(ovr),   32'(ovr_m));
    chk("tmo",   32'(tmo),   32'(tmo_m));
    chk("irq",   32'(irq),   32'(((thresh != 0) && (mq.size() >= int'(thresh))) || tmo_m));
    if (mq.size() > 0) chk("dout", 32'(dout), 32'(mq[0]));
  endtask

  // Drives one clock cycle of inputs, advances the model, checks after the edge.
  task automatic cycle(input logic stb, input logic [7:0] d, input logic rd, input logic clr);
    bit push, pop, was_empty;
    rx_stb = stb; rx_data = d; rd_en = rd; ovr_clr = clr;
    was_empty = (mq.size() == 0);
    push = stb && !prev_stb;
    pop  = rd && !was_empty;
    if (push || pop || was_empty) idle = 0;
    else if (idle < TMO)          idle++;
    if (push && (mq.size() == DEPTH) && !pop) ovr_m = 1'b1;
    else if (clr)                             ovr_m = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push && (mq.size() < DEPTH)) mq.push_back(d);
    prev_stb = stb;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic push_byte(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) pop_one();
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_stb = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0; thresh = '0;
    model_reset();
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovr",   32'(ovr),   32'd0);
    chk("rst_tmo",   32'(tmo),   32'd0);
    chk("rst_irq",   32'(irq),   32'd0);
    #4 rst = 1'b0;

    // Basic in-order delivery
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    chk("abc_count", 32'(count), 32'd3);
    chk("abc_head",  32'(dout),  32'h41);
    pop_one(); chk("pop1_dout", 32'(dout), 32'h42);
    pop_one(); chk("pop2_dout", 32'(dout), 32'h43);
    pop_one(); chk("pop3_empty", 32'(empty), 32'd1);
    chk("pop3_count", 32'(count), 32'd0);

    // Held strobe pushes once
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h55, 1'b0, 1'b0);
    chk("hold_count", 32'(count), 32'd1);
    drain();

    // Overrun on full, dropped byte absent
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    push_byte(8'h10);
    chk("ovr_full",  32'(full),  32'd1);
    chk("ovr_flag",  32'(ovr),   32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    drain();
    chk("ovr_drained", 32'(empty), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr", 32'(ovr), 32'd0);

    // Push and pop together on full, then on empty
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_ovr",   32'(ovr),   32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("fullpp_last", 32'(dout), 32'hAA);
      pop_one();
    end
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("emptypp_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Threshold interrupt
    thresh = 5'd4;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    chk("thr3_irq", 32'(irq), 32'd0);
    cycle(1'b1, 8'h04, 1'b0, 1'b0);
    chk("thr4_irq", 32'(irq), 32'd1);
    cycle(1'b0, 8'h04, 1'b1, 1'b0);
    chk("thr_pop_irq", 32'(irq), 32'd0);
    drain();
    thresh = '0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h60 + i));
    chk("thr0_irq", 32'(irq), 32'd0);
    drain();

    // Idle timeout
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      cycle(1'b0, 8'h99, 1'b0, 1'b0);
      chk("tmo_k", 32'(tmo), 32'(k == TMO));
    end
    chk("tmo_irq", 32'(irq), 32'd1);
    pop_one();
    chk("tmo_pop_tmo", 32'(tmo), 32'd0);
    chk("tmo_pop_irq", 32'(irq), 32'd0);

    // Asynchronous reset with data queued
    for (int i = 0; i < 5; i++) push_byte(8'(8'hB0 + i));
    chk("pre_rst_count", 32'(count), 32'd5);
    #3 rst = 1'b1;
    #1;
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_count", 32'(count), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    compare_all();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic s, r, c;
      if ($urandom_range(0, 99) == 0) thresh = 5'($urandom_range(0, DEPTH));
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 3) == 0) || (n > 1000 && n < 1100);
      c = ($urandom_range(0, 15) == 0);
      if (n >= 1200 && n < 1260) r = 1'b0;
      cycle(s, 8'($urandom), r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
